// File: rtl/scramble_pkg.sv
// Shared symbol constants, link-mode encodings and the per-symbol LFSR helper
// used by the DisplayPort main-link scrambler.
package scramble_pkg;

    localparam logic [7:0] SYM_K28_5 = 8'hBC;
    localparam logic [7:0] SYM_BS    = SYM_K28_5;
    localparam logic [7:0] SYM_SR    = 8'h1C;
    localparam logic [7:0] SYM_D10_2 = 8'h4A;
    localparam logic [7:0] SYM_D11_6 = 8'hCB;

    localparam logic [15:0] LFSR_SEED = 16'hFFFF;
    localparam logic [15:0] LFSR_TAPS = 16'h0039;

    localparam int                  BS_CNT_W   = 9;
    localparam logic [BS_CNT_W-1:0] BS_CNT_MAX = 9'd511;

    localparam logic [2:0] TPS2_LAST = 3'd4;

    typedef enum logic [1:0] {
        TP_NORMAL = 2'd0,
        TP_TPS1   = 2'd1,
        TP_TPS2   = 2'd2,
        TP_UNSCR  = 2'd3
    } tp_mode_e;

    typedef struct packed {
        logic [15:0] lfsr;
        logic [7:0]  ks;
    } lfsr_step_t;

    // Eight Galois steps, keystream bit 0 produced first.
    function automatic lfsr_step_t lfsr_step8(input logic [15:0] seed);
        lfsr_step_t r;
        logic       o;
        r.lfsr = seed;
        r.ks   = '0;
        o      = 1'b0;
        for (int b = 0; b < 8; b++) begin
            o       = r.lfsr[15];
            r.ks[b] = o;
            r.lfsr  = {r.lfsr[14:0], 1'b0} ^ (o ? LFSR_TAPS : 16'h0000);
        end
        return r;
    endfunction

    function automatic logic [15:0] tps2_word(input logic [2:0] idx);
        return (idx < 3'd2) ? {SYM_D11_6, SYM_K28_5} : {SYM_D10_2, SYM_D10_2};
    endfunction

    function automatic logic [1:0] tps2_isk(input logic [2:0] idx);
        return (idx < 3'd2) ? 2'b01 : 2'b00;
    endfunction

endpackage

// File: rtl/scramble_if.sv
// Two-lane symbol-pair bus between stuffer, scrambler and 8b/10b encoder,
// plus the link-mode select.
interface scramble_if;

    logic [1:0]  tp;
    logic [15:0] indat0;
    logic [15:0] indat1;
    logic [1:0]  inisk0;
    logic [1:0]  inisk1;
    logic [15:0] outdat0;
    logic [15:0] outdat1;
    logic [1:0]  outisk0;
    logic [1:0]  outisk1;

    modport master (
        output tp,
        output indat0,
        output indat1,
        output inisk0,
        output inisk1,
        input  outdat0,
        input  outdat1,
        input  outisk0,
        input  outisk1
    );

    modport slave (
        input  tp,
        input  indat0,
        input  indat1,
        input  inisk0,
        input  inisk1,
        output outdat0,
        output outdat1,
        output outisk0,
        output outisk1
    );

endinterface

// File: rtl/scramble_lane.sv
// Per-lane output stage: applies the shared keystream and SR substitution,
// or emits the training patterns, into the registered output word.
module scramble_lane
    import scramble_pkg::*;
(
    input  logic        dpclk,
    input  logic        reset,
    input  tp_mode_e    mode_i,
    input  logic [15:0] dat_i,
    input  logic [1:0]  isk_i,
    input  logic [15:0] ks_i,
    input  logic [1:0]  sub_sr_i,
    input  logic [2:0]  tps2_idx_i,
    output logic [15:0] dat_o,
    output logic [1:0]  isk_o
);

    logic [15:0] dat_q, dat_d;
    logic [1:0]  isk_q, isk_d;

    always_comb begin : p_lane_next
        dat_d = dat_i;
        isk_d = isk_i;
        case (mode_i)
            TP_TPS1: begin
                dat_d = {SYM_D10_2, SYM_D10_2};
                isk_d = 2'b00;
            end
            TP_TPS2: begin
                dat_d = tps2_word(tps2_idx_i);
                isk_d = tps2_isk(tps2_idx_i);
            end
            default: begin
                // Substitution decision comes from lane 0, even for lane 1.
                for (int p = 0; p < 2; p++) begin
                    if (sub_sr_i[p]) begin
                        dat_d[8*p +: 8] = SYM_SR;
                        isk_d[p]        = 1'b1;
                    end else if (mode_i == TP_NORMAL && !isk_i[p]) begin
                        dat_d[8*p +: 8] = dat_i[8*p +: 8] ^ ks_i[8*p +: 8];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge dpclk) begin : p_lane_reg
        if (reset) begin
            dat_q <= '0;
            isk_q <= '0;
        end else begin
            dat_q <= dat_d;
            isk_q <= isk_d;
        end
    end

    assign dat_o = dat_q;
    assign isk_o = isk_q;

endmodule

// File: rtl/scramble.sv
// DisplayPort two-lane scrambler: shared LFSR, BS counting with periodic SR
// substitution, and TPS1/TPS2 training pattern generation.
module scramble
    import scramble_pkg::*;
(
    input  logic      dpclk,
    input  logic      reset,
    scramble_if.slave bus
);

    tp_mode_e              mode;
    logic [1:0][15:0]      din;
    logic [1:0][1:0]       kin;
    logic [1:0][15:0]      dat_lane;
    logic [1:0][1:0]       isk_lane;

    logic [15:0]           lfsr_q, lfsr_d, lfsr_run;
    logic [BS_CNT_W-1:0]   bs_cnt_q, bs_cnt_d, bs_cnt_run;
    logic [2:0]            tps2_idx_q, tps2_idx_d;
    logic [15:0]           ks;
    logic [1:0]            sub_sr;

    assign mode = tp_mode_e'(bus.tp);
    assign din  = {bus.indat1, bus.indat0};
    assign kin  = {bus.inisk1, bus.inisk0};

    // Low byte then high byte; an SR (emitted or received) reseeds before the next symbol.
    always_comb begin : p_symbol_chain
        lfsr_step_t st;
        logic       is_bs;
        logic       is_sr;
        st         = '0;
        is_bs      = 1'b0;
        is_sr      = 1'b0;
        lfsr_run   = lfsr_q;
        bs_cnt_run = bs_cnt_q;
        ks         = '0;
        sub_sr     = '0;
        for (int p = 0; p < 2; p++) begin
            st              = lfsr_step8(lfsr_run);
            ks[8*p +: 8]    = st.ks;
            is_bs           = kin[0][p] && (din[0][8*p +: 8] == SYM_BS);
            sub_sr[p]       = is_bs && (bs_cnt_run == BS_CNT_MAX);
            if (is_bs) begin
                bs_cnt_run = bs_cnt_run + BS_CNT_W'(1);
            end
            is_sr    = sub_sr[p] || (kin[0][p] && (din[0][8*p +: 8] == SYM_SR));
            lfsr_run = is_sr ? LFSR_SEED : st.lfsr;
        end
    end

    // Training modes park the LFSR and BS counter so normal traffic restarts clean.
    always_comb begin : p_next_state
        lfsr_d     = LFSR_SEED;
        bs_cnt_d   = '0;
        tps2_idx_d = '0;
        case (mode)
            TP_NORMAL, TP_UNSCR: begin
                lfsr_d   = lfsr_run;
                bs_cnt_d = bs_cnt_run;
            end
            TP_TPS2: begin
                tps2_idx_d = (tps2_idx_q == TPS2_LAST) ? 3'd0 : tps2_idx_q + 3'd1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge dpclk) begin : p_state_reg
        if (reset) begin
            lfsr_q     <= LFSR_SEED;
            bs_cnt_q   <= '0;
            tps2_idx_q <= '0;
        end else begin
            lfsr_q     <= lfsr_d;
            bs_cnt_q   <= bs_cnt_d;
            tps2_idx_q <= tps2_idx_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            scramble_lane u_lane (
                .dpclk      (dpclk),
                .reset      (reset),
                .mode_i     (mode),
                .dat_i      (din[gi]),
                .isk_i      (kin[gi]),
                .ks_i       (ks),
                .sub_sr_i   (sub_sr),
                .tps2_idx_i (tps2_idx_q),
                .dat_o      (dat_lane[gi]),
                .isk_o      (isk_lane[gi])
            );
        end
    endgenerate

    assign bus.outdat0 = dat_lane[0];
    assign bus.outdat1 = dat_lane[1];
    assign bus.outisk0 = isk_lane[0];
    assign bus.outisk1 = isk_lane[1];

endmodule

// File: tb/tb_scramble.sv
// Directed bench for the two-lane scrambler: keystream, BS/SR handling,
// training patterns, mode changes and reset behaviour.
module tb_scramble;

    logic dpclk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    scramble_if bus ();

    scramble dut (
        .dpclk (dpclk),
        .reset (reset),
        .bus   (bus)
    );

    initial dpclk = 1'b0;
    always #5 dpclk = ~dpclk;

    logic [15:0] zero_exp [4] = '{16'h17FF, 16'h14C0, 16'hE7B2, 16'h8202};
    logic [15:0] tps2_exp [7] = '{16'hCBBC, 16'hCBBC, 16'h4A4A, 16'h4A4A,
                                  16'h4A4A, 16'hCBBC, 16'hCBBC};
    logic [1:0]  tps2_kexp [7] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};

    task automatic check_value(input string tag, input logic [15:0] obs,
                               input logic [15:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, obs, exp_v);
        end
    endtask

    // Apply one input word; on return the registered result of that word is visible.
    task automatic drive(input logic [1:0] tp, input logic [15:0] d0, input logic [1:0] k0,
                         input logic [15:0] d1, input logic [1:0] k1);
        bus.tp     = tp;
        bus.indat0 = d0;
        bus.inisk0 = k0;
        bus.indat1 = d1;
        bus.inisk1 = k1;
        @(posedge dpclk);
        #1;
    endtask

    task automatic expect_word(input string tag, input logic [15:0] e0, input logic [1:0] ek0,
                               input logic [15:0] e1, input logic [1:0] ek1);
        $display("txn %-10s out0=%h/%b out1=%h/%b", tag, bus.outdat0, bus.outisk0,
                 bus.outdat1, bus.outisk1);
        check_value({tag, ".dat0"}, bus.outdat0, e0);
        check_value({tag, ".isk0"}, {14'd0, bus.outisk0}, {14'd0, ek0});
        check_value({tag, ".dat1"}, bus.outdat1, e1);
        check_value({tag, ".isk1"}, {14'd0, bus.outisk1}, {14'd0, ek1});
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        drive(2'd0, 16'h0000, 2'b00, 16'h0000, 2'b00);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(2'd0, 16'h1234, 2'b11, 16'hABCD, 2'b10);
        drive(2'd0, 16'h1234, 2'b11, 16'hABCD, 2'b10);
        expect_word("reset", 16'h0000, 2'b00, 16'h0000, 2'b00);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            drive(2'd0, 16'h0000, 2'b00, 16'h0000, 2'b00);
            expect_word($sformatf("zeros%0d", i), zero_exp[i], 2'b00, zero_exp[i], 2'b00);
        end

        pulse_reset();
        drive(2'd0, 16'h00BC, 2'b01, 16'h00BC, 2'b01);
        expect_word("bs_low", 16'h17BC, 2'b01, 16'h17BC, 2'b01);
        drive(2'd0, 16'h0000, 2'b00, 16'h0000, 2'b00);
        expect_word("bs_next", 16'h14C0, 2'b00, 16'h14C0, 2'b00);

        pulse_reset();
        drive(2'd0, 16'h0000, 2'b00, 16'hFF00, 2'b00);
        expect_word("lane1_d", 16'h17FF, 2'b00, 16'hE8FF, 2'b00);
        drive(2'd0, 16'h001C, 2'b01, 16'h001C, 2'b01);
        expect_word("sr_pass", 16'hFF1C, 2'b01, 16'hFF1C, 2'b01);
        drive(2'd0, 16'h0000, 2'b00, 16'h0000, 2'b00);
        expect_word("sr_after", 16'hC017, 2'b00, 16'hC017, 2'b00);

        pulse_reset();
        drive(2'd0, 16'h0000, 2'b00, 16'h00BC, 2'b01);
        expect_word("lane1_k", 16'h17FF, 2'b00, 16'h17BC, 2'b01);

        pulse_reset();
        drive(2'd3, 16'h1234, 2'b00, 16'h5678, 2'b10);
        expect_word("unscr", 16'h1234, 2'b00, 16'h5678, 2'b10);
        drive(2'd0, 16'h0000, 2'b00, 16'h0000, 2'b00);
        expect_word("unscr_adv", 16'h14C0, 2'b00, 16'h14C0, 2'b00);

        pulse_reset();
        for (int i = 0; i < 1024; i++) begin
            drive(2'd0, 16'h00BC, 2'b01, 16'h00BC, 2'b01);
            if (i == 0) begin
                expect_word("bs0", 16'h17BC, 2'b01, 16'h17BC, 2'b01);
            end else if (i == 510) begin
                check_value("bs510.lo", {8'h00, bus.outdat0[7:0]}, 16'h00BC);
                $display("txn bs510      out0=%h/%b", bus.outdat0, bus.outisk0);
            end else if (i == 511) begin
                expect_word("bs511", 16'hFF1C, 2'b01, 16'hFF1C, 2'b01);
            end else if (i == 512) begin
                expect_word("bs512", 16'hC0BC, 2'b01, 16'hC0BC, 2'b01);
            end else if (i == 1023) begin
                expect_word("bs1023", 16'hFF1C, 2'b01, 16'hFF1C, 2'b01);
            end
        end

        for (int i = 0; i < 7; i++) begin
            drive(2'd2, 16'h0000, 2'b00, 16'h0000, 2'b00);
            expect_word($sformatf("tps2_%0d", i), tps2_exp[i], tps2_kexp[i],
                        tps2_exp[i], tps2_kexp[i]);
        end
        drive(2'd0, 16'h0000, 2'b00, 16'h0000, 2'b00);
        expect_word("post_tps2a", 16'h17FF, 2'b00, 16'h17FF, 2'b00);
        drive(2'd0, 16'h0000, 2'b00, 16'h0000, 2'b00);
        expect_word("post_tps2b", 16'h14C0, 2'b00, 16'h14C0, 2'b00);

        drive(2'd2, 16'h0000, 2'b00, 16'h0000, 2'b00);
        drive(2'd2, 16'h0000, 2'b00, 16'h0000, 2'b00);
        drive(2'd2, 16'h0000, 2'b00, 16'h0000, 2'b00);
        expect_word("tps2_mid", 16'h4A4A, 2'b00, 16'h4A4A, 2'b00);
        drive(2'd0, 16'h0000, 2'b00, 16'h0000, 2'b00);
        expect_word("tps2_gap", 16'h17FF, 2'b00, 16'h17FF, 2'b00);
        drive(2'd2, 16'h0000, 2'b00, 16'h0000, 2'b00);
        expect_word("tps2_rst", 16'hCBBC, 2'b01, 16'hCBBC, 2'b01);

        drive(2'd0, 16'h0000, 2'b00, 16'h0000, 2'b00);
        drive(2'd0, 16'h0000, 2'b00, 16'h0000, 2'b00);
        expect_word("pre_tps1", 16'h14C0, 2'b00, 16'h14C0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            drive(2'd1, 16'h0000, 2'b00, 16'h0000, 2'b00);
            expect_word($sformatf("tps1_%0d", i), 16'h4A4A, 2'b00, 16'h4A4A, 2'b00);
        end
        drive(2'd0, 16'h0000, 2'b00, 16'h0000, 2'b00);
        expect_word("post_tps1a", 16'h17FF, 2'b00, 16'h17FF, 2'b00);
        drive(2'd0, 16'h0000, 2'b00, 16'h0000, 2'b00);
        expect_word("post_tps1b", 16'h14C0, 2'b00, 16'h14C0, 2'b00);

        reset = 1'b1;
        drive(2'd0, 16'h0000, 2'b00, 16'h0000, 2'b00);
        expect_word("mid_rst", 16'h0000, 2'b00, 16'h0000, 2'b00);
        drive(2'd2, 16'h0000, 2'b00, 16'h0000, 2'b00);
        expect_word("rst_tps2", 16'h0000, 2'b00, 16'h0000, 2'b00);
        reset = 1'b0;
        drive(2'd0, 16'h0000, 2'b00, 16'h0000, 2'b00);
        expect_word("restart", 16'h17FF, 2'b00, 16'h17FF, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
